// File: rtl/mp5_addr_map.sv
// Phantom-slot address map: turns a real packet whose phantom reserved a FIFO slot into an insert.
// Optional same-cycle record/lookup forwarding is enabled with `define MP5_ADDR_MAP_BYPASS_EN.
module mp5_addr_map #(
    parameter int unsigned NUM_PIPELINES = 8,
    parameter int unsigned FIFO_SIZE     = 8,
    parameter int unsigned MAP_DEPTH     = 16,
    // Packet layout: [15:0] id, [16] is_phantom, [PKT_W-1:17] payload.
    parameter int unsigned PKT_W         = 32,
    localparam int unsigned FIFO_W       = $clog2(NUM_PIPELINES),
    localparam int unsigned ADDR_W       = $clog2(FIFO_SIZE),
    localparam int unsigned IDX_W        = $clog2(MAP_DEPTH),
    localparam int unsigned OCC_W        = $clog2(MAP_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_valid,
    input  logic [15:0]       rec_id,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic [FIFO_W-1:0] rec_fifo_id,
    input  logic              req_valid,
    input  logic [PKT_W-1:0]  req_pkt,
    input  logic [FIFO_W-1:0] req_fifo_id,
    output logic [PKT_W-1:0]  out_pkt,
    output logic              out_push,
    output logic              out_insert,
    output logic [ADDR_W-1:0] out_addr,
    output logic [FIFO_W-1:0] out_fifo_id,
    output logic [OCC_W-1:0]  occupancy,
    output logic              overflow,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    logic [MAP_DEPTH-1:0] ent_valid;
    logic [15:0]          ent_id   [MAP_DEPTH];
    logic [ADDR_W-1:0]    ent_addr [MAP_DEPTH];
    logic [FIFO_W-1:0]    ent_fifo [MAP_DEPTH];

    logic [15:0]          req_id;
    logic                 req_phantom;
    logic                 lookup;
    logic                 bypass_hit;
    logic [MAP_DEPTH-1:0] match_vec;
    logic [MAP_DEPTH-1:0] hit_clear;
    logic [MAP_DEPTH-1:0] dup_vec;
    logic [MAP_DEPTH-1:0] free_vec;
    logic [IDX_W-1:0]     hit_idx;
    logic [IDX_W-1:0]     dup_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 hit;
    logic                 miss;
    logic                 store;
    logic                 do_dup;
    logic                 do_alloc;
    logic                 drop;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [MAP_DEPTH-1:0] valid_d;
    logic [OCC_W-1:0]     occ_d;

    assign req_id      = req_pkt[15:0];
    assign req_phantom = req_pkt[16];
    assign lookup      = req_valid && !req_phantom;

`ifdef MP5_ADDR_MAP_BYPASS_EN
    assign bypass_hit = rec_valid && lookup && (rec_id == req_id);
`else
    assign bypass_hit = 1'b0;
`endif

    // Lowest-index priority encoders for lookup, duplicate-record and free-slot searches.
    always_comb begin
        match_vec = '0;
        free_vec  = '0;
        hit_idx   = '0;
        free_idx  = '0;
        for (int i = int'(MAP_DEPTH) - 1; i >= 0; i--) begin
            match_vec[i] = ent_valid[i] && (ent_id[i] == req_id);
            free_vec[i]  = !ent_valid[i];
            if (match_vec[i]) begin
                hit_idx = IDX_W'(i);
            end
            if (free_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign hit  = lookup && !bypass_hit && (|match_vec);
    assign miss = lookup && !bypass_hit && !(|match_vec);

    // An entry consumed by this cycle's hit is not a duplicate target for a same-cycle record.
    always_comb begin
        hit_clear = '0;
        dup_vec   = '0;
        dup_idx   = '0;
        for (int i = int'(MAP_DEPTH) - 1; i >= 0; i--) begin
            hit_clear[i] = hit && (hit_idx == IDX_W'(i));
            dup_vec[i]   = ent_valid[i] && !hit_clear[i] && (ent_id[i] == rec_id);
            if (dup_vec[i]) begin
                dup_idx = IDX_W'(i);
            end
        end
    end

    assign store    = rec_valid && !bypass_hit;
    assign do_dup   = store && (|dup_vec);
    assign do_alloc = store && !(|dup_vec) && (|free_vec);
    assign drop     = store && !(|dup_vec) && !(|free_vec);
    assign wr_en    = do_dup || do_alloc;
    assign wr_idx   = do_dup ? dup_idx : free_idx;

    always_comb begin
        valid_d = ent_valid & ~hit_clear;
        if (do_alloc) begin
            valid_d[free_idx] = 1'b1;
        end
        occ_d = occupancy + OCC_W'(do_alloc) - OCC_W'(hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid   <= '0;
            out_pkt     <= '0;
            out_push    <= 1'b0;
            out_insert  <= 1'b0;
            out_addr    <= '0;
            out_fifo_id <= '0;
            occupancy   <= '0;
            overflow    <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            ent_valid <= valid_d;
            occupancy <= occ_d;
            if (wr_en) begin
                ent_id[wr_idx]   <= rec_id;
                ent_addr[wr_idx] <= rec_addr;
                ent_fifo[wr_idx] <= rec_fifo_id;
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            out_push   <= 1'b0;
            out_insert <= 1'b0;
            if (req_valid) begin
                out_pkt <= req_pkt;
                if (bypass_hit) begin
                    out_insert  <= 1'b1;
                    out_addr    <= rec_addr;
                    out_fifo_id <= rec_fifo_id;
                end else if (hit) begin
                    out_insert  <= 1'b1;
                    out_addr    <= ent_addr[hit_idx];
                    out_fifo_id <= ent_fifo[hit_idx];
                end else begin
                    out_push    <= 1'b1;
                    out_addr    <= '0;
                    out_fifo_id <= req_fifo_id;
                end
            end

            if ((hit || bypass_hit) && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mp5_addr_map.sv
// Self-checking bench for mp5_addr_map: directed scenarios plus a randomized run against a
// reservation-table model kept as an associative array keyed by packet id.
module tb_mp5_addr_map;

    logic        clk = 1'b0;
    logic        rst;
    logic        rec_valid;
    logic [15:0] rec_id;
    logic [2:0]  rec_addr;
    logic [2:0]  rec_fifo_id;
    logic        req_valid;
    logic [31:0] req_pkt;
    logic [2:0]  req_fifo_id;
    logic [31:0] out_pkt;
    logic        out_push;
    logic        out_insert;
    logic [2:0]  out_addr;
    logic [2:0]  out_fifo_id;
    logic [4:0]  occupancy;
    logic        overflow;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp5_addr_map dut (
        .clk         (clk),
        .rst         (rst),
        .rec_valid   (rec_valid),
        .rec_id      (rec_id),
        .rec_addr    (rec_addr),
        .rec_fifo_id (rec_fifo_id),
        .req_valid   (req_valid),
        .req_pkt     (req_pkt),
        .req_fifo_id (req_fifo_id),
        .out_pkt     (out_pkt),
        .out_push    (out_push),
        .out_insert  (out_insert),
        .out_addr    (out_addr),
        .out_fifo_id (out_fifo_id),
        .occupancy   (occupancy),
        .overflow    (overflow),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // Reference model: reservations keyed by id, capacity 16.
    typedef struct packed {
        logic [2:0] addr;
        logic [2:0] fifo;
    } res_t;

    res_t        resmap [int];
    logic        exp_push, exp_insert, exp_ovf;
    logic [2:0]  exp_addr, exp_fifo;
    logic [31:0] exp_pkt, exp_hits, exp_miss;
    int          exp_occ;

    function automatic logic [31:0] mk_pkt(input logic [15:0] id, input logic ph);
        logic [14:0] payload;
        payload = 15'($urandom);
        return {payload, ph, id};
    endfunction

    task automatic model_step();
        int   pre;
        logic bypass;
        logic ph;
        int   id;
        if (rst) begin
            resmap.delete();
            exp_push = 0; exp_insert = 0; exp_addr = 0; exp_fifo = 0; exp_pkt = 0;
            exp_ovf = 0; exp_hits = 0; exp_miss = 0; exp_occ = 0;
            return;
        end
        pre = resmap.num();
        ph  = req_pkt[16];
        id  = int'(req_pkt[15:0]);
`ifdef MP5_ADDR_MAP_BYPASS_EN
        bypass = rec_valid && req_valid && !ph && (rec_id == req_pkt[15:0]);
`else
        bypass = 1'b0;
`endif
        exp_push = 0;
        exp_insert = 0;
        if (req_valid) begin
            exp_pkt = req_pkt;
            if (ph) begin
                exp_push = 1; exp_addr = 0; exp_fifo = req_fifo_id;
            end else if (bypass) begin
                exp_insert = 1; exp_addr = rec_addr; exp_fifo = rec_fifo_id;
                if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
            end else if (resmap.exists(id)) begin
                exp_insert = 1; exp_addr = resmap[id].addr; exp_fifo = resmap[id].fifo;
                resmap.delete(id);
                if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
            end else begin
                exp_push = 1; exp_addr = 0; exp_fifo = req_fifo_id;
                if (exp_miss != 32'hFFFF_FFFF) exp_miss++;
            end
        end
        // Slots freed by a hit only become allocatable next cycle, hence 'pre'.
        if (rec_valid && !bypass) begin
            if (resmap.exists(int'(rec_id))) resmap[int'(rec_id)] = '{rec_addr, rec_fifo_id};
            else if (pre < 16) resmap[int'(rec_id)] = '{rec_addr, rec_fifo_id};
            else exp_ovf = 1;
        end
        exp_occ = resmap.num();
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rec_valid = 0;
        req_valid = 0;
    endtask

    task automatic rec(input logic [15:0] id, input logic [2:0] a, input logic [2:0] f);
        rec_valid = 1; rec_id = id; rec_addr = a; rec_fifo_id = f;
    endtask

    task automatic req(input logic [15:0] id, input logic ph, input logic [2:0] f);
        req_valid = 1; req_pkt = mk_pkt(id, ph); req_fifo_id = f;
    endtask

    task automatic do_reset();
        rst = 1; idle();
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            rec_valid = 1'($urandom); rec_id = 16'($urandom); rec_addr = 3'($urandom);
            rec_fifo_id = 3'($urandom); req_valid = 1'($urandom);
            req_pkt = $urandom; req_fifo_id = 3'($urandom);
            cycle();
        end
        checks++;
        if ({out_push, out_insert, out_addr, out_fifo_id, out_pkt} !== '0) begin
            errors++;
            $display("FAIL reset_out: got push=%0b ins=%0b addr=%0d fifo=%0d pkt=%h want all 0",
                     out_push, out_insert, out_addr, out_fifo_id, out_pkt);
        end
        checks++;
        if ({occupancy, overflow, hit_count, miss_count} !== '0) begin
            errors++;
            $display("FAIL reset_stats: got occ=%0d ovf=%0b hit=%0d miss=%0d want all 0",
                     occupancy, overflow, hit_count, miss_count);
        end
        rst = 0; idle();
    endtask

    task automatic test_record_hit();
        do_reset();
        rec(16'h0042, 3'd5, 3'd3);
        cycle();
        idle();
        cycle();
        req(16'h0042, 1'b0, 3'd1);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_addr, out_fifo_id} !== {1'b0, 1'b1, 3'd5, 3'd3}) begin
            errors++;
            $display("FAIL record_hit_out: got push=%0b ins=%0b addr=%0d fifo=%0d want 0 1 5 3",
                     out_push, out_insert, out_addr, out_fifo_id);
        end
        checks++;
        if (occupancy !== 5'd0 || hit_count !== 32'd1 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL record_hit_stats: got occ=%0d hit=%0d miss=%0d want 0 1 0",
                     occupancy, hit_count, miss_count);
        end
    endtask

    task automatic test_phantom_miss();
        do_reset();
        req(16'd7, 1'b1, 3'd2);
        cycle();
        checks++;
        if ({out_push, out_insert, out_addr, out_fifo_id} !== {1'b1, 1'b0, 3'd0, 3'd2} ||
            hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL phantom: got push=%0b ins=%0b addr=%0d fifo=%0d hit=%0d miss=%0d want 1 0 0 2 0 0",
                     out_push, out_insert, out_addr, out_fifo_id, hit_count, miss_count);
        end
        req(16'd9, 1'b0, 3'd6);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b1, 1'b0, 3'd6} || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL miss: got push=%0b ins=%0b fifo=%0d miss=%0d want 1 0 6 1",
                     out_push, out_insert, out_fifo_id, miss_count);
        end
        cycle();
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b0, 1'b0, 3'd6}) begin
            errors++;
            $display("FAIL idle_hold: got push=%0b ins=%0b fifo=%0d want 0 0 6",
                     out_push, out_insert, out_fifo_id);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rec(16'h0200 + 16'(i), 3'(i), 3'(i + 1));
            cycle();
        end
        rec(16'h0100, 3'd4, 3'd4);
        cycle();
        idle();
        checks++;
        if (overflow !== 1'b1 || occupancy !== 5'd16) begin
            errors++;
            $display("FAIL overflow_flag: got ovf=%0b occ=%0d want 1 16", overflow, occupancy);
        end
        req(16'h0100, 1'b0, 3'd2);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b1, 1'b0, 3'd2} || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL dropped_id_miss: got push=%0b ins=%0b fifo=%0d miss=%0d want 1 0 2 1",
                     out_push, out_insert, out_fifo_id, miss_count);
        end
        rec(16'h0205, 3'd7, 3'd0);
        cycle();
        idle();
        checks++;
        if (occupancy !== 5'd16) begin
            errors++;
            $display("FAIL dup_overwrite_occ: got occ=%0d want 16", occupancy);
        end
        req(16'h0205, 1'b0, 3'd1);
        cycle();
        idle();
        checks++;
        if ({out_insert, out_addr, out_fifo_id} !== {1'b1, 3'd7, 3'd0} || occupancy !== 5'd15) begin
            errors++;
            $display("FAIL dup_overwrite_hit: got ins=%0b addr=%0d fifo=%0d occ=%0d want 1 7 0 15",
                     out_insert, out_addr, out_fifo_id, occupancy);
        end
        rec(16'h0301, 3'd1, 3'd1);
        cycle();
        // Full map: a same-cycle hit must not make room for this record.
        rec(16'h0302, 3'd3, 3'd3);
        req(16'h0200, 1'b0, 3'd0);
        cycle();
        idle();
        checks++;
        if ({out_insert, out_addr, out_fifo_id} !== {1'b1, 3'd0, 3'd1} || occupancy !== 5'd15) begin
            errors++;
            $display("FAIL full_hit_record: got ins=%0b addr=%0d fifo=%0d occ=%0d want 1 0 1 15",
                     out_insert, out_addr, out_fifo_id, occupancy);
        end
        req(16'h0302, 1'b0, 3'd6);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b1, 1'b0, 3'd6} || miss_count !== 32'd2) begin
            errors++;
            $display("FAIL full_hit_dropped: got push=%0b ins=%0b fifo=%0d miss=%0d want 1 0 6 2",
                     out_push, out_insert, out_fifo_id, miss_count);
        end
    endtask

    task automatic test_collision();
        do_reset();
        rec(16'h0011, 3'd2, 3'd4);
        req(16'h0011, 1'b0, 3'd1);
        cycle();
        idle();
`ifdef MP5_ADDR_MAP_BYPASS_EN
        checks++;
        if ({out_push, out_insert, out_addr, out_fifo_id} !== {1'b0, 1'b1, 3'd2, 3'd4} ||
            occupancy !== 5'd0 || hit_count !== 32'd1) begin
            errors++;
            $display("FAIL bypass: got push=%0b ins=%0b addr=%0d fifo=%0d occ=%0d hit=%0d want 0 1 2 4 0 1",
                     out_push, out_insert, out_addr, out_fifo_id, occupancy, hit_count);
        end
`else
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b1, 1'b0, 3'd1} || occupancy !== 5'd1) begin
            errors++;
            $display("FAIL collide_push: got push=%0b ins=%0b fifo=%0d occ=%0d want 1 0 1 1",
                     out_push, out_insert, out_fifo_id, occupancy);
        end
        req(16'h0011, 1'b0, 3'd1);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_addr, out_fifo_id} !== {1'b0, 1'b1, 3'd2, 3'd4} ||
            occupancy !== 5'd0) begin
            errors++;
            $display("FAIL collide_next: got push=%0b ins=%0b addr=%0d fifo=%0d occ=%0d want 0 1 2 4 0",
                     out_push, out_insert, out_addr, out_fifo_id, occupancy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rec(16'h0051 + 16'(i), 3'(i + 1), 3'(i + 2));
            cycle();
        end
        idle();
        req(16'h0052, 1'b0, 3'd5);
        rst = 1;
        cycle();
        rst = 0;
        checks++;
        if (out_push !== 1'b0 || out_insert !== 1'b0 || occupancy !== 5'd0 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_squash: got push=%0b ins=%0b occ=%0d hit=%0d want 0 0 0 0",
                     out_push, out_insert, occupancy, hit_count);
        end
        req(16'h0052, 1'b0, 3'd5);
        cycle();
        idle();
        checks++;
        if ({out_push, out_insert, out_fifo_id} !== {1'b1, 1'b0, 3'd5} || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_miss: got push=%0b ins=%0b fifo=%0d miss=%0d want 1 0 5 1",
                     out_push, out_insert, out_fifo_id, miss_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 149) == 0);
            rec_valid   = ($urandom_range(0, 99) < 55);
            rec_id      = 16'($urandom_range(0, 23));
            rec_addr    = 3'($urandom);
            rec_fifo_id = 3'($urandom);
            req_valid   = ($urandom_range(0, 99) < 60);
            req_pkt     = mk_pkt(16'($urandom_range(0, 23)), $urandom_range(0, 3) == 0);
            req_fifo_id = 3'($urandom);
            cycle();
            checks++;
            if ({out_push, out_insert} !== {exp_push, exp_insert}) begin
                errors++;
                $display("FAIL rand_strobe[%0d]: got push=%0b ins=%0b want %0b %0b",
                         n, out_push, out_insert, exp_push, exp_insert);
            end
            checks++;
            if ({out_pkt, out_addr, out_fifo_id} !== {exp_pkt, exp_addr, exp_fifo}) begin
                errors++;
                $display("FAIL rand_data[%0d]: got pkt=%h addr=%0d fifo=%0d want %h %0d %0d",
                         n, out_pkt, out_addr, out_fifo_id, exp_pkt, exp_addr, exp_fifo);
            end
            checks++;
            if ({occupancy, overflow, hit_count, miss_count} !==
                {5'(exp_occ), exp_ovf, exp_hits, exp_miss}) begin
                errors++;
                $display("FAIL rand_stats[%0d]: got occ=%0d ovf=%0b hit=%0d miss=%0d want %0d %0b %0d %0d",
                         n, occupancy, overflow, hit_count, miss_count,
                         exp_occ, exp_ovf, exp_hits, exp_miss);
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1; rec_valid = 0; rec_id = 0; rec_addr = 0; rec_fifo_id = 0;
        req_valid = 0; req_pkt = 0; req_fifo_id = 0;
        test_reset();
        test_record_hit();
        test_phantom_miss();
        test_overflow();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
